fw_scoreboard: RTL and testbench

- Parametrised forwarding and hazard unit for the dual-issue SPU pipes.
- Holds its own per-pipe shift register of in-flight destination descriptors (valid, rt address, ready stage), so issue logic only supplies issue-time information.
- For every source operand of every pipe: selects the youngest ready in-flight result, or the register-file value, or raises a stall when the youngest producer is not yet ready.
- Also drives the register-file write port and a one-cycle write-through bypass register.

---
 rtl/defines_pkg.sv | 12 +
 rtl/fw_track_pipe.sv | 53 +++++
 rtl/fw_scoreboard.sv | 91 +++++++++
 tb/tb_fw_scoreboard.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/defines_pkg.sv
// defines_pkg: shared constants and types for the SPU pipeline blocks
package defines_pkg;
    localparam int FW_ADDR_W = 7;
    localparam int FW_LAT_W = 3;
    localparam int FW_DEPTH = 7;
    localparam int FW_FLUSH_DEPTH = 3;
    typedef struct packed {
        logic vld;
        logic [FW_ADDR_W-1:0] addr;
        logic [FW_LAT_W-1:0] lat;
    } fw_entry_t;
endpackage

// File: rtl/fw_track_pipe.sv
// fw_track_pipe: one pipe's in-flight destination descriptors, ready flags and writeback bypass register
module fw_track_pipe
    import defines_pkg::*;
#(
    parameter int DEPTH = FW_DEPTH,
    parameter int ADDR_W = FW_ADDR_W,
    parameter int LAT_W = FW_LAT_W,
    parameter int DATA_W = 128,
    parameter int FLUSH_DEPTH = FW_FLUSH_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic ins_vld,
    input  logic [ADDR_W-1:0] ins_addr,
    input  logic [LAT_W-1:0] ins_lat,
    input  logic flush,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DEPTH-1:0] ent_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
    output logic [DEPTH-1:0] ent_rdy,
    output logic byp_vld,
    output logic [ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0] byp_data
);
    logic [DEPTH-1:0][LAT_W-1:0] ent_lat;
    logic [DEPTH-2:0] kill;
    logic [LAT_W-1:0] lat_n;
    // out-of-range latencies resolve at the writeback stage
    assign lat_n = (ins_lat == '0 || ins_lat > LAT_W'(DEPTH)) ? LAT_W'(DEPTH) : ins_lat;
    for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
        assign ent_rdy[i] = ent_lat[i] <= LAT_W'(i + 1);
    end
    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_kill
        assign kill[i] = flush && (i < FLUSH_DEPTH);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_vld <= '0;
            ent_addr <= '0;
            ent_lat <= '0;
            byp_vld <= 1'b0;
            byp_addr <= '0;
            byp_data <= '0;
        end else begin
            ent_vld <= {ent_vld[DEPTH-2:0] & ~kill, ins_vld & ~flush};
            ent_addr <= {ent_addr[DEPTH-2:0], ins_addr};
            ent_lat <= {ent_lat[DEPTH-2:0], lat_n};
            byp_vld <= ent_vld[DEPTH-1];
            byp_addr <= ent_addr[DEPTH-1];
            byp_data <= wb_data;
        end
    end
endmodule

// File: rtl/fw_scoreboard.sv
// fw_scoreboard: operand forwarding, hazard stall and RF writeback for the dual-issue SPU pipes
module fw_scoreboard
    import defines_pkg::*;
#(
    parameter int NUM_PIPES = 2,
    parameter int NUM_SRCS = 3,
    parameter int DEPTH = FW_DEPTH,
    parameter int ADDR_W = FW_ADDR_W,
    parameter int DATA_W = 128,
    parameter int LAT_W = FW_LAT_W,
    parameter int FLUSH_DEPTH = FW_FLUSH_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic [NUM_PIPES-1:0] issue_vld,
    input  logic [NUM_PIPES*ADDR_W-1:0] issue_rt,
    input  logic [NUM_PIPES*LAT_W-1:0] issue_lat,
    input  logic flush,
    input  logic [NUM_PIPES*DEPTH*DATA_W-1:0] res_data,
    input  logic [NUM_PIPES*NUM_SRCS-1:0] src_vld,
    input  logic [NUM_PIPES*NUM_SRCS*ADDR_W-1:0] src_addr,
    input  logic [NUM_PIPES*NUM_SRCS*DATA_W-1:0] src_rf_data,
    output logic [NUM_PIPES*NUM_SRCS*DATA_W-1:0] src_fw_data,
    output logic stall,
    output logic [NUM_PIPES-1:0] wb_vld,
    output logic [NUM_PIPES*ADDR_W-1:0] wb_addr,
    output logic [NUM_PIPES*DATA_W-1:0] wb_data
);
    localparam int NS = NUM_PIPES * NUM_SRCS;
    logic [NUM_PIPES-1:0][DEPTH-1:0] ent_vld, ent_rdy;
    logic [NUM_PIPES-1:0][DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [NUM_PIPES-1:0] byp_vld;
    logic [NUM_PIPES-1:0][ADDR_W-1:0] byp_addr;
    logic [NUM_PIPES-1:0][DATA_W-1:0] byp_data;
    logic [NS-1:0] hit, rdy;
    logic [NS-1:0][DATA_W-1:0] sel;
    for (genvar p = 0; p < NUM_PIPES; p++) begin : g_pipe
        assign wb_vld[p] = ent_vld[p][DEPTH-1];
        assign wb_addr[p*ADDR_W +: ADDR_W] = ent_addr[p][DEPTH-1];
        assign wb_data[p*DATA_W +: DATA_W] = res_data[(p*DEPTH+DEPTH-1)*DATA_W +: DATA_W];
        fw_track_pipe #(
            .DEPTH(DEPTH),
            .ADDR_W(ADDR_W),
            .LAT_W(LAT_W),
            .DATA_W(DATA_W),
            .FLUSH_DEPTH(FLUSH_DEPTH)
        ) u_trk (
            .clk(clk),
            .rst(rst),
            .ins_vld(issue_vld[p] & ~stall),
            .ins_addr(issue_rt[p*ADDR_W +: ADDR_W]),
            .ins_lat(issue_lat[p*LAT_W +: LAT_W]),
            .flush(flush),
            .wb_data(wb_data[p*DATA_W +: DATA_W]),
            .ent_vld(ent_vld[p]),
            .ent_addr(ent_addr[p]),
            .ent_rdy(ent_rdy[p]),
            .byp_vld(byp_vld[p]),
            .byp_addr(byp_addr[p]),
            .byp_data(byp_data[p])
        );
    end
    // scan oldest to youngest so the last match is the youngest producer
    always_comb begin
        hit = '0;
        rdy = '0;
        sel = '0;
        for (int j = 0; j < NS; j++) begin
            for (int p = 0; p < NUM_PIPES; p++) begin
                if (byp_vld[p] && byp_addr[p] == src_addr[j*ADDR_W +: ADDR_W]) begin
                    hit[j] = 1'b1;
                    rdy[j] = 1'b1;
                    sel[j] = byp_data[p];
                end
            end
            for (int s = DEPTH - 1; s >= 0; s--) begin
                for (int p = 0; p < NUM_PIPES; p++) begin
                    if (ent_vld[p][s] && ent_addr[p][s] == src_addr[j*ADDR_W +: ADDR_W]) begin
                        hit[j] = 1'b1;
                        rdy[j] = ent_rdy[p][s];
                        sel[j] = res_data[(p*DEPTH+s)*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end
    for (genvar j = 0; j < NS; j++) begin : g_src
        assign src_fw_data[j*DATA_W +: DATA_W] = (hit[j] && rdy[j]) ? sel[j] : src_rf_data[j*DATA_W +: DATA_W];
    end
    assign stall = |(src_vld & hit & ~rdy);
endmodule

// File: tb/tb_fw_scoreboard.sv
// tb_fw_scoreboard: directed vector table plus hand sequences for fw_scoreboard
module tb_fw_scoreboard;
    localparam int NP = 2, NSRC = 3, D = 7, AW = 7, DW = 128, LW = 3;
    typedef struct {
        int gap, iv, rt0, l0, rt1, l1, fl, sv, a0, a1, es, ew, c0, c1;
    } row_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NP-1:0] issue_vld;
    logic [NP*AW-1:0] issue_rt;
    logic [NP*LW-1:0] issue_lat;
    logic flush;
    logic [NP*D*DW-1:0] res_data;
    logic [NP*NSRC-1:0] src_vld;
    logic [NP*NSRC*AW-1:0] src_addr;
    logic [NP*NSRC*DW-1:0] src_rf_data;
    logic [NP*NSRC*DW-1:0] src_fw_data;
    logic stall;
    logic [NP-1:0] wb_vld;
    logic [NP*AW-1:0] wb_addr;
    logic [NP*DW-1:0] wb_data;
    logic [31:0] salt;
    logic [DW-1:0] exp_b;
    int n_chk = 0, n_fail = 0;
    row_t rows[$];

    fw_scoreboard dut (
        .clk(clk), .rst(rst), .issue_vld(issue_vld), .issue_rt(issue_rt), .issue_lat(issue_lat),
        .flush(flush), .res_data(res_data), .src_vld(src_vld), .src_addr(src_addr),
        .src_rf_data(src_rf_data), .src_fw_data(src_fw_data), .stall(stall),
        .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd(int p, int s);
        return {salt, 32'(p), 32'(s), 32'hC0DE_0000};
    endfunction

    function automatic logic [DW-1:0] rf(int j);
        return {32'hF11E_0000, 32'(j), 64'h5EED};
    endfunction

    // code 0 = RF value, 1..7 pipe0 stage, 11..17 pipe1 stage, 20+p = bypass of pipe p
    function automatic logic [DW-1:0] exp_fw(int c, int j);
        return c == 0 ? rf(j) : c >= 20 ? rd(c - 20, D) : rd(c / 10, c % 10);
    endfunction

    function automatic row_t mk(int gap, int iv, int rt0, int l0, int rt1, int l1, int fl,
                                int sv, int a0, int a1, int es, int ew, int c0, int c1);
        row_t r;
        r = '{gap, iv, rt0, l0, rt1, l1, fl, sv, a0, a1, es, ew, c0, c1};
        return r;
    endfunction

    task automatic set_res;
        for (int p = 0; p < NP; p++)
            for (int s = 1; s <= D; s++)
                res_data[(p*D+s-1)*DW +: DW] = rd(p, s);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle;
        issue_vld = '0;
        issue_rt = '0;
        issue_lat = '0;
        flush = 1'b0;
        src_vld = '0;
        src_addr = {(NP*NSRC){7'd127}};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        salt = 32'h1;
        set_res();
        for (int j = 0; j < NP*NSRC; j++) src_rf_data[j*DW +: DW] = rf(j);
        idle();
        // plain forwarding, then bypass
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 10, 2, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 10, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 2, 2));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 3, 3));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 4, 4));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 5, 5));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 6, 6));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 1, 7, 7));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 20, 20));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 10, 10, 0, 0, 0, 0));
        // younger ready producer beats older one
        rows.push_back(mk(0, 1, 20, 6, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 20, 2, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 20, 20, 0, 0, 3, 3));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 20, 20, 0, 0, 4, 4));
        // unready younger producer shadows ready older one
        rows.push_back(mk(4, 1, 21, 1, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 21, 5, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 21, 21, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 21, 21, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 21, 21, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 21, 21, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 21, 21, 0, 0, 5, 5));
        // both pipes write the same register
        rows.push_back(mk(3, 3, 33, 1, 33, 1, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 33, 33, 0, 0, 11, 11));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 33, 33, 0, 0, 13, 13));
        rows.push_back(mk(3, 0, 0, 0, 0, 0, 0, 33, 33, 33, 0, 3, 17, 17));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 33, 33, 0, 0, 21, 21));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 33, 33, 0, 0, 0, 0));
        // early flush kills the entry and blocks insertion
        rows.push_back(mk(0, 1, 40, 6, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 40, 40, 1, 0, 0, 0));
        rows.push_back(mk(0, 2, 0, 0, 41, 1, 1, 0, 40, 41, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 40, 41, 0, 0, 0, 0));
        rows.push_back(mk(3, 0, 0, 0, 0, 0, 0, 33, 40, 41, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 40, 41, 0, 0, 0, 0));
        // late flush leaves the entry alone; flush with stall inserts nothing
        rows.push_back(mk(0, 1, 40, 6, 0, 0, 0, 33, 5, 5, 0, 0, 0, 0));
        rows.push_back(mk(4, 2, 0, 0, 43, 1, 1, 1, 40, 43, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 40, 43, 0, 0, 6, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 40, 43, 0, 1, 7, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 40, 43, 0, 0, 20, 0));
        // src_vld gating, lat 0 treated as DEPTH
        rows.push_back(mk(0, 3, 50, 7, 51, 0, 0, 0, 50, 51, 0, 0, 0, 0));
        rows.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 50, 51, 0, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 50, 51, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32, 50, 51, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 50, 51, 1, 0, 0, 0));
        rows.push_back(mk(0, 0, 0, 0, 0, 0, 0, 33, 50, 51, 0, 3, 7, 17));

        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", DW'(stall), DW'(0));
        chk("reset wb_vld", DW'(wb_vld), DW'(0));
        rst = 1'b1;
        #1;
        chk("reset wb_addr", DW'(wb_addr), DW'(0));
        chk("reset fw src0", src_fw_data[DW-1:0], rf(0));

        foreach (rows[i]) begin
            row_t r;
            r = rows[i];
            idle();
            repeat (r.gap) tick();
            issue_vld = 2'(r.iv);
            issue_rt = {7'(r.rt1), 7'(r.rt0)};
            issue_lat = {3'(r.l1), 3'(r.l0)};
            flush = 1'(r.fl);
            src_vld = 6'(r.sv);
            src_addr[6:0] = 7'(r.a0);
            src_addr[41:35] = 7'(r.a1);
            #1;
            chk($sformatf("row%0d stall", i), DW'(stall), DW'(r.es));
            chk($sformatf("row%0d wb_vld", i), DW'(wb_vld), DW'(r.ew));
            chk($sformatf("row%0d fw src0", i), src_fw_data[0 +: DW], exp_fw(r.c0, 0));
            chk($sformatf("row%0d fw src5", i), src_fw_data[5*DW +: DW], exp_fw(r.c1, 5));
            tick();
        end

        // writeback fields and registered bypass data
        idle();
        tick();
        tick();
        issue_vld = 2'b10;
        issue_rt = {7'd77, 7'd0};
        issue_lat = {3'd3, 3'd0};
        tick();
        idle();
        repeat (6) tick();
        chk("wb vld pipe1", DW'(wb_vld), DW'(2));
        chk("wb addr pipe1", DW'(wb_addr[13:7]), DW'(77));
        chk("wb data pipe1", wb_data[DW +: DW], rd(1, D));
        exp_b = rd(1, D);
        tick();
        salt = 32'h2;
        set_res();
        src_vld = 6'd1;
        src_addr[6:0] = 7'd77;
        #1;
        chk("bypass data held", src_fw_data[0 +: DW], exp_b);
        chk("bypass stall", DW'(stall), DW'(0));
        chk("bypass wb_vld", DW'(wb_vld), DW'(0));

        // asynchronous reset with entries in flight
        idle();
        tick();
        issue_vld = 2'b11;
        issue_rt = {7'd61, 7'd60};
        issue_lat = {3'd7, 3'd1};
        tick();
        idle();
        src_vld = 6'd33;
        src_addr[6:0] = 7'd60;
        src_addr[41:35] = 7'd61;
        #1;
        chk("pre-reset stall", DW'(stall), DW'(1));
        chk("pre-reset fw src0", src_fw_data[0 +: DW], rd(0, 1));
        rst = 1'b0;
        #1;
        chk("async reset stall", DW'(stall), DW'(0));
        chk("async reset wb_vld", DW'(wb_vld), DW'(0));
        chk("async reset fw src0", src_fw_data[0 +: DW], rf(0));
        chk("async reset fw src5", src_fw_data[5*DW +: DW], rf(5));
        tick();
        rst = 1'b1;
        #1;
        chk("post-reset stall", DW'(stall), DW'(0));
        chk("post-reset fw src0", src_fw_data[0 +: DW], rf(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
